// File: rtl/m_mode_trap_unit_if.sv
// m_mode_trap_unit_if
// Purpose: bundles the CSR access channel, trap/MRET inputs, interrupt
// sources and PC redirect of the M-mode trap unit into one interface.
// Ports (signals):
//   csr_address_i / csr_op_i / csr_write_data_i  CSR request from execute
//   csr_read_data_o / csr_read_data_valid_o       registered old CSR value
//   csr_illegal_o                                  illegal access pulse
//   exception_*_i, mret_i                          commit-stage trap events
//   irq_accept_i, interrupt_pc_i                   interrupt boundary info
//   irq_external_i / irq_timer_i / irq_software_i  MEIP/MTIP/MSIP levels
//   irq_local_i                                    platform interrupt levels
//   trap_redirect_o / trap_target_o                PC redirect pulse + target
// Modports: master = core side, slave = trap unit side.
interface m_mode_trap_unit_if #(
    parameter int XLEN          = 64,
    parameter int NUM_LOCAL_IRQ = 16
);
    localparam int LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;

    logic [11:0]     csr_address_i;
    logic [2:0]      csr_op_i;
    logic [XLEN-1:0] csr_write_data_i;
    logic [XLEN-1:0] csr_read_data_o;
    logic            csr_read_data_valid_o;
    logic            csr_illegal_o;
    logic            exception_valid_i;
    logic [5:0]      exception_cause_i;
    logic [XLEN-1:0] exception_pc_i;
    logic [XLEN-1:0] exception_tval_i;
    logic            mret_i;
    logic            irq_accept_i;
    logic [XLEN-1:0] interrupt_pc_i;
    logic            irq_external_i;
    logic            irq_timer_i;
    logic            irq_software_i;
    logic [LW-1:0]   irq_local_i;
    logic            trap_redirect_o;
    logic [XLEN-1:0] trap_target_o;

    modport master (
        output csr_address_i, csr_op_i, csr_write_data_i,
        output exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
        output mret_i, irq_accept_i, interrupt_pc_i,
        output irq_external_i, irq_timer_i, irq_software_i, irq_local_i,
        input  csr_read_data_o, csr_read_data_valid_o, csr_illegal_o,
        input  trap_redirect_o, trap_target_o
    );

    modport slave (
        input  csr_address_i, csr_op_i, csr_write_data_i,
        input  exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
        input  mret_i, irq_accept_i, interrupt_pc_i,
        input  irq_external_i, irq_timer_i, irq_software_i, irq_local_i,
        output csr_read_data_o, csr_read_data_valid_o, csr_illegal_o,
        output trap_redirect_o, trap_target_o
    );
endinterface

// File: rtl/m_mode_trap_unit.sv
// m_mode_trap_unit
// Purpose: M-mode CSR file and trap controller. Handles CSR read/write/set/
// clear with registered read data, trap entry for exceptions and prioritised
// interrupts, MRET, mstatus MIE/MPIE stacking and direct/vectored mtvec.
// Ports:
//   clock_i   rising-edge clock
//   reset_ni  synchronous active-low reset
//   bus       m_mode_trap_unit_if.slave (CSR channel, trap inputs, irqs,
//             redirect outputs)
module m_mode_trap_unit #(
    parameter int          XLEN          = 64,
    parameter int          NUM_LOCAL_IRQ = 16,
    parameter logic [63:0] BOOT_ADDRESS  = 64'h8000_0000,
    parameter bit          VECTORED_EN   = 1'b1
) (
    input logic              clock_i,
    input logic              reset_ni,
    m_mode_trap_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_SET   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    function automatic logic [XLEN-1:0] mie_mask();
        logic [XLEN-1:0] mask;
        mask     = '0;
        mask[3]  = 1'b1;
        mask[7]  = 1'b1;
        mask[11] = 1'b1;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) mask[16+i] = 1'b1;
        return mask;
    endfunction

    function automatic logic [XLEN-1:0] misa_value();
        logic [XLEN-1:0] v;
        v = '0;
        v[8] = 1'b1;
        v[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
        return v;
    endfunction

    localparam logic [XLEN-1:0] MIE_MASK    = mie_mask();
    localparam logic [XLEN-1:0] MISA        = misa_value();
    localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_RESET = {BOOT_ADDRESS[XLEN-1:2], 2'b00};

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] target_q, read_data_q;
    logic            read_valid_q, illegal_q;

    logic [XLEN-1:0] mstatus_value, old_value, new_value, mip_d, pending;
    logic [XLEN-1:0] mcause_d, target_d, mtvec_base;
    logic            csr_access, csr_is_write, csr_in_map, csr_illegal, csr_write_en;
    logic            mtvec_mode_ok;
    logic            take_exception, take_interrupt, take_mret;
    logic [5:0]      irq_cause, trap_cause;

    // CSR decode: select the old value, flag illegal accesses and form the
    // value a write/set/clear would produce.
    always_comb begin
        mstatus_value        = '0;
        mstatus_value[3]     = mstatus_mie_q;
        mstatus_value[7]     = mstatus_mpie_q;
        mstatus_value[12:11] = 2'b11;
        csr_is_write = (bus.csr_op_i == OP_WRITE) || (bus.csr_op_i == OP_SET) ||
                       (bus.csr_op_i == OP_CLEAR);
        csr_access   = csr_is_write || (bus.csr_op_i == OP_READ);
        csr_in_map   = 1'b1;
        old_value    = '0;
        case (bus.csr_address_i)
            ADDR_MSTATUS:  old_value = mstatus_value;
            ADDR_MISA:     old_value = MISA;
            ADDR_MIE:      old_value = mie_q;
            ADDR_MTVEC:    old_value = mtvec_q;
            ADDR_MSCRATCH: old_value = mscratch_q;
            ADDR_MEPC:     old_value = mepc_q;
            ADDR_MCAUSE:   old_value = mcause_q;
            ADDR_MTVAL:    old_value = mtval_q;
            ADDR_MIP:      old_value = mip_q;
            ADDR_MHARTID:  old_value = '0;
            default:       csr_in_map = 1'b0;
        endcase
        csr_illegal = csr_access &&
                      (!csr_in_map || (csr_is_write && bus.csr_address_i[11:10] == 2'b11));
        csr_write_en = csr_is_write && !csr_illegal;
        case (bus.csr_op_i)
            OP_WRITE: new_value = bus.csr_write_data_i;
            OP_SET:   new_value = old_value | bus.csr_write_data_i;
            OP_CLEAR: new_value = old_value & ~bus.csr_write_data_i;
            default:  new_value = old_value;
        endcase
        // Reserved modes, and VECTORED when it is disabled, keep the old mode.
        mtvec_mode_ok = (new_value[1:0] == 2'b00) ||
                        (new_value[1:0] == 2'b01 && VECTORED_EN);
    end

    // Interrupt sources as they will appear in mip next cycle, and the
    // highest-priority pending interrupt: MEI > MSI > MTI > local lines,
    // where the highest local index wins (later assignments override).
    always_comb begin
        mip_d     = '0;
        mip_d[3]  = bus.irq_software_i;
        mip_d[7]  = bus.irq_timer_i;
        mip_d[11] = bus.irq_external_i;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_d[16+i] = bus.irq_local_i[i];
        pending   = mie_q & mip_q;
        irq_cause = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            if (pending[16+i]) irq_cause = 6'(16 + i);
        end
        if (pending[7])  irq_cause = 6'd7;
        if (pending[3])  irq_cause = 6'd3;
        if (pending[11]) irq_cause = 6'd11;
    end

    // Trap decision and next state. Events are only considered in IDLE;
    // the REDIRECT cycle ignores them and always falls back to IDLE.
    always_comb begin
        state_d        = state_q;
        take_exception = 1'b0;
        take_interrupt = 1'b0;
        take_mret      = 1'b0;
        if (state_q == IDLE) begin
            if (bus.exception_valid_i) begin
                take_exception = 1'b1;
            end else if (mstatus_mie_q && bus.irq_accept_i && (|pending)) begin
                take_interrupt = 1'b1;
            end else if (bus.mret_i) begin
                take_mret = 1'b1;
            end
            if (take_exception || take_interrupt || take_mret) state_d = REDIRECT;
        end else begin
            state_d = IDLE;
        end
    end

    // Trap cause word and redirect target computed from the pre-edge state.
    always_comb begin
        trap_cause            = take_interrupt ? irq_cause : bus.exception_cause_i;
        mcause_d              = XLEN'(trap_cause);
        mcause_d[XLEN-1]      = take_interrupt;
        mtvec_base            = mtvec_q & ALIGN_MASK;
        if (take_mret) begin
            target_d = mepc_q;
        end else if (take_interrupt && mtvec_q[1:0] == 2'b01) begin
            target_d = mtvec_base + (XLEN'(irq_cause) << 2);
        end else begin
            target_d = mtvec_base;
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // CSR state, read response and trap side effects. Trap/MRET updates are
    // written after the CSR write so they take precedence on the registers
    // both touch, while CSR writes to other registers still land.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            target_q       <= '0;
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            mip_q        <= mip_d;
            read_valid_q <= csr_access && !csr_illegal;
            read_data_q  <= (csr_access && !csr_illegal) ? old_value : '0;
            illegal_q    <= csr_illegal;
            if (csr_write_en) begin
                case (bus.csr_address_i)
                    ADDR_MSTATUS: begin
                        mstatus_mie_q  <= new_value[3];
                        mstatus_mpie_q <= new_value[7];
                    end
                    ADDR_MIE:      mie_q <= new_value & MIE_MASK;
                    ADDR_MTVEC: begin
                        mtvec_q[XLEN-1:2] <= new_value[XLEN-1:2];
                        if (mtvec_mode_ok) mtvec_q[1:0] <= new_value[1:0];
                    end
                    ADDR_MSCRATCH: mscratch_q <= new_value;
                    ADDR_MEPC:     mepc_q     <= new_value & ALIGN_MASK;
                    ADDR_MCAUSE:   mcause_q   <= new_value;
                    ADDR_MTVAL:    mtval_q    <= new_value;
                    default: ;
                endcase
            end
            if (take_exception || take_interrupt) begin
                mepc_q         <= (take_exception ? bus.exception_pc_i : bus.interrupt_pc_i)
                                  & ALIGN_MASK;
                mcause_q       <= mcause_d;
                mtval_q        <= take_exception ? bus.exception_tval_i : '0;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
            if (take_exception || take_interrupt || take_mret) target_q <= target_d;
        end
    end

    assign bus.csr_read_data_o       = read_data_q;
    assign bus.csr_read_data_valid_o = read_valid_q;
    assign bus.csr_illegal_o         = illegal_q;
    assign bus.trap_redirect_o       = (state_q == REDIRECT);
    assign bus.trap_target_o         = (state_q == REDIRECT) ? target_q : '0;
endmodule

// File: tb/tb_m_mode_trap_unit.sv
// tb_m_mode_trap_unit
// Purpose: self-checking bench for m_mode_trap_unit (XLEN=64, 16 local irqs).
// A register-level model predicts the outputs after every rising edge; a
// compare process checks them each falling edge. Directed steps pin known
// values, then randomized traffic exercises CSR ops, traps and resets.
module tb_m_mode_trap_unit;
    localparam int NIRQ = 16;
    localparam logic [63:0] MIE_MASK = (((64'd1 << NIRQ) - 64'd1) << 16) | 64'h888;

    logic clock = 1'b0;
    logic resetN;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   checkOn     = 1'b0;

    bit          mMie, mMpie;
    logic [63:0] mMieReg, mMip, mMtvec, mMscratch, mMepc, mMcause, mMtval;
    bit          expRvalid = 1'b0, expIllegal = 1'b0, expRedirect = 1'b0;
    logic [63:0] expRdata = '0, expTarget = '0;

    logic [11:0] addrs [12] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hF14, 12'h7C0, 12'hF11};

    m_mode_trap_unit_if #(.XLEN(64), .NUM_LOCAL_IRQ(NIRQ)) bus ();

    m_mode_trap_unit #(
        .XLEN(64), .NUM_LOCAL_IRQ(NIRQ), .BOOT_ADDRESS(64'h8000_0000), .VECTORED_EN(1'b1)
    ) dut (
        .clock_i  (clock),
        .reset_ni (resetN),
        .bus      (bus)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports a miss.
    task automatic compare(input string name, input logic [63:0] actual,
                           input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Architectural view of a CSR read; known=0 for unmapped addresses.
    function automatic logic [63:0] modelRead(input logic [11:0] a, output bit known);
        known = 1'b1;
        case (a)
            12'h300: return (64'(mMie) << 3) | (64'(mMpie) << 7) | (64'd3 << 11);
            12'h301: return 64'h8000_0000_0000_0100;
            12'h304: return mMieReg;
            12'h305: return mMtvec;
            12'h340: return mMscratch;
            12'h341: return mMepc;
            12'h342: return mMcause;
            12'h343: return mMtval;
            12'h344: return mMip;
            12'hF14: return 64'd0;
            default: begin known = 1'b0; return 64'd0; end
        endcase
    endfunction

    // Walk the interrupt priority list and return the first pending cause.
    function automatic int highestIrq(input logic [63:0] p);
        int order[$];
        order = {11, 3, 7};
        for (int i = NIRQ - 1; i >= 0; i--) order.push_back(16 + i);
        foreach (order[k]) if (p[order[k]]) return order[k];
        return 0;
    endfunction

    // Advance the model by one rising edge using the inputs sampled there.
    task automatic modelStep();
        logic [63:0] old, nv, pending, base, d;
        bit known, isRead, isWrite, bad;
        int kind, cause;
        if (!resetN) begin
            mMie = 0; mMpie = 0; mMieReg = 0; mMip = 0; mMtvec = 64'h8000_0000;
            mMscratch = 0; mMepc = 0; mMcause = 0; mMtval = 0;
            expRvalid = 0; expIllegal = 0; expRdata = 0; expRedirect = 0; expTarget = 0;
            return;
        end
        isRead  = (bus.csr_op_i == 3'd1);
        isWrite = (bus.csr_op_i >= 3'd2) && (bus.csr_op_i <= 3'd4);
        old     = modelRead(bus.csr_address_i, known);
        bad     = (isRead || isWrite) &&
                  (!known || (isWrite && bus.csr_address_i[11:10] == 2'b11));
        expIllegal = bad;
        expRvalid  = (isRead || isWrite) && !bad;
        expRdata   = expRvalid ? old : 64'd0;
        d = bus.csr_write_data_i;
        case (bus.csr_op_i)
            3'd2:    nv = d;
            3'd3:    nv = old | d;
            3'd4:    nv = old & ~d;
            default: nv = old;
        endcase
        kind = 0; cause = 0;
        pending = mMieReg & mMip;
        if (!expRedirect) begin
            if (bus.exception_valid_i) begin
                kind = 1; cause = int'(bus.exception_cause_i);
            end else if (mMie && bus.irq_accept_i && pending != 0) begin
                kind = 2; cause = highestIrq(pending);
            end else if (bus.mret_i) begin
                kind = 3;
            end
        end
        base = mMtvec & ~64'd3;
        if (kind == 3)                             expTarget = mMepc;
        else if (kind == 2 && mMtvec[1:0] == 2'd1) expTarget = base + 64'(4 * cause);
        else                                       expTarget = base;
        expRedirect = (kind != 0);
        if (isWrite && !bad) begin
            case (bus.csr_address_i)
                12'h300: if (kind == 0) begin mMie = nv[3]; mMpie = nv[7]; end
                12'h304: mMieReg = nv & MIE_MASK;
                12'h305: mMtvec = {nv[63:2], (nv[1:0] <= 2'd1) ? nv[1:0] : mMtvec[1:0]};
                12'h340: mMscratch = nv;
                12'h341: if (kind != 1 && kind != 2) mMepc = nv & ~64'd3;
                12'h342: if (kind != 1 && kind != 2) mMcause = nv;
                12'h343: if (kind != 1 && kind != 2) mMtval = nv;
                default: ;
            endcase
        end
        if (kind == 1 || kind == 2) begin
            mMepc   = ((kind == 1) ? bus.exception_pc_i : bus.interrupt_pc_i) & ~64'd3;
            mMcause = 64'(cause) | ((kind == 2) ? (64'd1 << 63) : 64'd0);
            mMtval  = (kind == 1) ? bus.exception_tval_i : 64'd0;
            mMpie   = mMie;
            mMie    = 0;
        end else if (kind == 3) begin
            mMie  = mMpie;
            mMpie = 1;
        end
        mMip = (64'(bus.irq_external_i) << 11) | (64'(bus.irq_timer_i) << 7) |
               (64'(bus.irq_software_i) << 3) | (64'(bus.irq_local_i) << 16);
    endtask

    // One clock: model follows the rising edge, control returns on the falling edge.
    task automatic tick();
        @(posedge clock);
        modelStep();
        @(negedge clock);
    endtask

    // Compare every meaningful DUT output against the model.
    task automatic checkOutput();
        compare("read_valid", 64'(bus.csr_read_data_valid_o), 64'(expRvalid));
        compare("illegal", 64'(bus.csr_illegal_o), 64'(expIllegal));
        compare("redirect", 64'(bus.trap_redirect_o), 64'(expRedirect));
        if (expRvalid)   compare("read_data", bus.csr_read_data_o, expRdata);
        if (expRedirect) compare("target", bus.trap_target_o, expTarget);
    endtask

    // Compare process on the falling edge, away from the active edge.
    always @(negedge clock) if (checkOn) checkOutput();

    // Present one CSR request for a cycle, then drop the pulse-type inputs.
    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [63:0] data);
        bus.csr_op_i         = op;
        bus.csr_address_i    = addr;
        bus.csr_write_data_i = data;
        tick();
        bus.csr_op_i          = 3'd0;
        bus.exception_valid_i = 1'b0;
        bus.mret_i            = 1'b0;
    endtask

    task automatic readExpect(input string name, input logic [11:0] addr,
                              input logic [63:0] value);
        applyStimulus(3'd1, addr, 64'd0);
        compare({name, "_valid"}, 64'(bus.csr_read_data_valid_o), 64'd1);
        compare(name, bus.csr_read_data_o, value);
    endtask

    task automatic raiseException(input logic [5:0] cause, input logic [63:0] pc,
                                  input logic [63:0] tval);
        bus.exception_valid_i = 1'b1;
        bus.exception_cause_i = cause;
        bus.exception_pc_i    = pc;
        bus.exception_tval_i  = tval;
    endtask

    // Directed steps with literal expectations, then randomized traffic.
    initial begin
        resetN = 1'b0;
        bus.csr_op_i = 0; bus.csr_address_i = 0; bus.csr_write_data_i = 0;
        bus.exception_valid_i = 0; bus.exception_cause_i = 0;
        bus.exception_pc_i = 0; bus.exception_tval_i = 0; bus.mret_i = 0;
        bus.irq_accept_i = 0; bus.interrupt_pc_i = 0;
        bus.irq_external_i = 0; bus.irq_timer_i = 0; bus.irq_software_i = 0;
        bus.irq_local_i = 0;
        tick();
        checkOn = 1'b1;
        tick();
        compare("reset_redirect", 64'(bus.trap_redirect_o), 64'd0);
        compare("reset_valid", 64'(bus.csr_read_data_valid_o), 64'd0);
        compare("reset_illegal", 64'(bus.csr_illegal_o), 64'd0);
        resetN = 1'b1;

        readExpect("mtvec_reset", 12'h305, 64'h8000_0000);
        applyStimulus(3'd1, 12'h7C0, 64'd0);
        compare("unmapped_illegal", 64'(bus.csr_illegal_o), 64'd1);
        compare("unmapped_valid", 64'(bus.csr_read_data_valid_o), 64'd0);
        applyStimulus(3'd2, 12'hF14, 64'd5);
        compare("mhartid_write_illegal", 64'(bus.csr_illegal_o), 64'd1);

        applyStimulus(3'd2, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
        readExpect("mie_all", 12'h304, 64'h0000_0000_FFFF_0888);
        applyStimulus(3'd4, 12'h304, 64'h800);
        readExpect("mie_clear", 12'h304, 64'h0000_0000_FFFF_0088);
        readExpect("misa", 12'h301, 64'h8000_0000_0000_0100);

        applyStimulus(3'd2, 12'h300, 64'h8);
        raiseException(6'd2, 64'h8000_0100, 64'hDEAD);
        applyStimulus(3'd0, 12'h000, 64'd0);
        compare("exc_redirect", 64'(bus.trap_redirect_o), 64'd1);
        compare("exc_target", bus.trap_target_o, 64'h8000_0000);
        compare("model_mcause", mMcause, 64'd2);
        tick();
        compare("exc_pulse_end", 64'(bus.trap_redirect_o), 64'd0);
        readExpect("exc_mcause", 12'h342, 64'd2);
        readExpect("exc_mepc", 12'h341, 64'h8000_0100);
        readExpect("exc_mtval", 12'h343, 64'hDEAD);
        readExpect("exc_mstatus", 12'h300, 64'h1880);

        applyStimulus(3'd2, 12'h305, 64'h8000_1001);
        applyStimulus(3'd2, 12'h304, 64'h880);
        applyStimulus(3'd2, 12'h300, 64'h8);
        bus.irq_timer_i = 1; bus.irq_external_i = 1; bus.irq_accept_i = 1;
        bus.interrupt_pc_i = 64'h8000_0444;
        tick();
        compare("irq_mip_latency", 64'(bus.trap_redirect_o), 64'd0);
        tick();
        compare("irq_redirect", 64'(bus.trap_redirect_o), 64'd1);
        compare("irq_target", bus.trap_target_o, 64'h8000_102C);
        bus.irq_timer_i = 0; bus.irq_external_i = 0; bus.irq_accept_i = 0;
        tick();
        readExpect("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
        readExpect("irq_mepc", 12'h341, 64'h8000_0444);

        applyStimulus(3'd2, 12'h300, 64'h8);
        raiseException(6'd5, 64'h8000_0200, 64'h0);
        bus.mret_i = 1'b1;
        applyStimulus(3'd0, 12'h000, 64'd0);
        compare("exc_over_mret_target", bus.trap_target_o, 64'h8000_1000);
        tick();
        readExpect("no_mret_mstatus", 12'h300, 64'h1880);
        bus.mret_i = 1'b1;
        applyStimulus(3'd0, 12'h000, 64'd0);
        compare("mret_redirect", 64'(bus.trap_redirect_o), 64'd1);
        compare("mret_target", bus.trap_target_o, 64'h8000_0200);
        tick();
        readExpect("mret_mstatus", 12'h300, 64'h1888);

        raiseException(6'd4, 64'h8000_0300, 64'h1);
        applyStimulus(3'd0, 12'h000, 64'd0);
        raiseException(6'd6, 64'h8000_0400, 64'h2);
        applyStimulus(3'd0, 12'h000, 64'd0);
        compare("second_exc_ignored", 64'(bus.trap_redirect_o), 64'd0);
        readExpect("first_exc_mcause", 12'h342, 64'd4);
        readExpect("first_exc_mepc", 12'h341, 64'h8000_0300);

        raiseException(6'd7, 64'h8000_0500, 64'h3);
        applyStimulus(3'd0, 12'h000, 64'd0);
        resetN = 1'b0;
        tick();
        compare("reset_abort_redirect", 64'(bus.trap_redirect_o), 64'd0);
        resetN = 1'b1;
        tick();
        compare("reset_no_late_pulse", 64'(bus.trap_redirect_o), 64'd0);
        compare("model_mtvec_reset", mMtvec, 64'h8000_0000);
        readExpect("abort_mtvec", 12'h305, 64'h8000_0000);
        readExpect("abort_mstatus", 12'h300, 64'h1800);
        readExpect("abort_mcause", 12'h342, 64'd0);
        readExpect("abort_mie", 12'h304, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            bus.csr_op_i          = 3'($urandom_range(0, 7));
            bus.csr_address_i     = addrs[$urandom_range(0, 11)];
            bus.csr_write_data_i  = {$urandom, $urandom};
            bus.exception_valid_i = ($urandom_range(0, 15) == 0);
            bus.exception_cause_i = 6'($urandom);
            bus.exception_pc_i    = {$urandom, $urandom};
            bus.exception_tval_i  = {$urandom, $urandom};
            bus.mret_i            = ($urandom_range(0, 11) == 0);
            bus.irq_accept_i      = 1'($urandom_range(0, 1));
            bus.interrupt_pc_i    = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                bus.irq_external_i = ($urandom_range(0, 3) == 0);
                bus.irq_timer_i    = ($urandom_range(0, 3) == 0);
                bus.irq_software_i = ($urandom_range(0, 3) == 0);
                bus.irq_local_i    = 16'($urandom & $urandom & $urandom);
            end
            resetN = ($urandom_range(0, 299) != 0);
            tick();
        end

        resetN = 1'b1;
        bus.csr_op_i = 0; bus.exception_valid_i = 0; bus.mret_i = 0;
        tick();
        tick();
        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
